cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the pipelined MIPS core.
- Consumes the fetch-address fault flag from the PC register, plus other stage exception codes and the six hardware interrupt lines.
- Produces the one-cycle INT_REQ that forces the PC register to load the handler address past a stall.
- Holds SR/Cause/EPC/PRId; serves mfc0/mtc0/eret.

Parameters:
- WIDTH, 32, datapath width.
- HANDLER_ADDR, 32'h0000_4180, exception entry PC driven on handler_pc.
- PRID_VAL, 32'h0000_0000, read-only PRId contents.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- we  in  1  mtc0 write enable.
- addr  in  5  CP0 register index (12 SR, 13 Cause, 14 EPC, 15 PRId).
- din  in  WIDTH  mtc0 write data.
- dout  out  WIDTH  mfc0 read data (combinational).
- victim_pc  in  WIDTH  PC of the instruction in the commit stage.
- victim_bd  in  1  that instruction is in a branch delay slot.
- exc_valid  in  1  synchronous exception present (includes fetch PC_EXP as AdEL).
- exc_code  in  5  ExcCode of that exception.
- hw_int  in  6  level hardware interrupt lines.
- eret  in  1  eret committing this cycle.
- INT_REQ  out  1  take exception/interrupt now (combinational).
- handler_pc  out  WIDTH  constant HANDLER_ADDR.
- epc_out  out  WIDTH  current EPC, for eret redirect.

Behaviour:
- Reset values: SR=0, Cause=0, EPC=0; dout follows the reset registers (PRId=PRID_VAL); INT_REQ=0.
- SR fields: IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause fields: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- Cause.IP is registered from hw_int every cycle, including while EXL=1. Software reads the one-cycle-delayed copy.
- irq = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL, using the registered IP.
- INT_REQ = (irq | exc_valid) & ~SR.EXL. Exceptions while EXL=1 are ignored.
- Interrupt has priority over exc_valid in the same cycle. Recorded ExcCode=0 when irq wins, else exc_code.
- On a posedge with INT_REQ=1:
  - EXL<=1.
  - BD<=victim_bd.
  - EPC<= victim_bd ? victim_pc-4 : victim_pc, stored unmodified (misaligned PC kept verbatim).
  - ExcCode per the priority rule above.
  - INT_REQ deasserts the next cycle because EXL=1.
- mtc0 (we=1, INT_REQ=0):
  - SR writes only IM/EXL/IE.
  - EPC write stores din with [1:0] cleared.
  - Cause and PRId are read-only; writes are ignored.
  - Any other index is a no-op.
- we with INT_REQ=1 in the same cycle: the write is dropped and exception capture wins.
- eret (INT_REQ=0): EXL<=0 next edge. epc_out holds EPC, stable for the redirect.
- eret with INT_REQ=1: eret is ignored; cannot normally occur since EXL must be 1 for eret.
- mtc0 to EPC in the same cycle as eret: EPC updates and epc_out shows the old value this cycle. Software must not do this; no hazard logic is provided.
- dout = register selected by addr. Unmapped indices read 0. Reads reflect the pre-edge value with no bypass.
- Reset mid-handler: all state returns to reset values the next edge; any pending interrupt is lost until IE is set again.
- No arithmetic besides victim_pc-4 (WIDTH bits, wraps modulo 2^WIDTH).

Decomposition:
- Shared package cp0_pkg:
  - register indices 12–15;
  - SR/Cause bit positions;
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - HANDLER_ADDR default.
- One sub-module, cp0_int_arb: combinational priority of irq vs exc_valid, producing INT_REQ and the selected ExcCode. Registers stay in the top.

Test Plan:
- Reset, then read 12/13/14/15 → 0, 0, 0, PRID_VAL; INT_REQ=0.
- mtc0 SR=32'h0000_0401 (IM[10], IE), then hw_int=6'b000001 → INT_REQ rises one cycle after the line rises. Next edge: EXL=1, Cause=32'h0000_0400 (IP[10], ExcCode 0), EPC=victim_pc=32'h0000_3010; INT_REQ low after.
- exc_valid=1, exc_code=4, victim_pc=32'h0000_2ffc, victim_bd=1 → EPC=32'h0000_2ff8, Cause=32'h8000_0010.
- hw_int and exc_valid asserted in the same cycle (IE=1, IM set) → ExcCode=0. A second exc_valid while EXL=1 → INT_REQ stays 0 and EPC is unchanged.
- mtc0 EPC=32'h0000_3007, then eret → EPC reads 32'h0000_3004, EXL clears the next edge, and a pending irq re-raises INT_REQ the following cycle.
- we to SR coincident with INT_REQ, and we to Cause=32'hFFFF_FFFF → both writes are ignored. Assert reset while EXL=1 → all registers zero next edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register indices, field positions, ExcCodes.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

endpackage

// File: rtl/cp0_int_arb.sv
// Picks interrupt over synchronous exception and gates both with EXL.
module cp0_int_arb
    import cp0_pkg::*;
(
    input  logic       irq,
    input  logic       exc_valid,
    input  logic       exl,
    input  logic [4:0] exc_code,
    output logic       int_req,
    output logic [4:0] sel_code
);

    always_comb begin
        int_req  = (irq | exc_valid) & ~exl;
        sel_code = irq ? EXC_INT : exc_code;
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause, EPC, PRId,
// mfc0/mtc0/eret and the one-cycle INT_REQ redirect.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] HANDLER_ADDR = WIDTH'(HANDLER_ADDR_DEF),
    parameter logic [WIDTH-1:0] PRID_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [WIDTH-1:0] victim_pc,
    input  logic             victim_bd,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [5:0]       hw_int,
    input  logic             eret,
    output logic             INT_REQ,
    output logic [WIDTH-1:0] handler_pc,
    output logic [WIDTH-1:0] epc_out
);

    logic [5:0]       sr_im;
    logic             sr_exl;
    logic             sr_ie;
    logic             cause_bd;
    logic [5:0]       cause_ip;
    logic [4:0]       cause_exc;
    logic [WIDTH-1:0] epc;

    logic             irq;
    logic [4:0]       sel_code;
    logic [WIDTH-1:0] sr_word;
    logic [WIDTH-1:0] cause_word;
    logic             unused_din;

    assign unused_din = ^{din[WIDTH-1:16], din[9:2]};

    assign irq = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;

    cp0_int_arb u_arb (
        .irq       (irq),
        .exc_valid (exc_valid),
        .exl       (sr_exl),
        .exc_code  (exc_code),
        .int_req   (INT_REQ),
        .sel_code  (sel_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            // IP tracks the lines even inside a handler
            cause_ip <= hw_int;
            if (INT_REQ) begin
                sr_exl    <= 1'b1;
                cause_bd  <= victim_bd;
                cause_exc <= sel_code;
                epc       <= victim_bd ? victim_pc - WIDTH'(4) : victim_pc;
            end else begin
                if (we) begin
                    case (addr)
                        CP0_SR: begin
                            sr_im  <= din[SR_IM_HI:SR_IM_LO];
                            sr_exl <= din[SR_EXL];
                            sr_ie  <= din[SR_IE];
                        end
                        CP0_EPC: epc <= {din[WIDTH-1:2], 2'b00};
                        default: ;
                    endcase
                end
                if (eret) sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_word                       = '0;
        sr_word[SR_IM_HI:SR_IM_LO]    = sr_im;
        sr_word[SR_EXL]               = sr_exl;
        sr_word[SR_IE]                = sr_ie;
        cause_word                    = '0;
        cause_word[CAUSE_BD]          = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    always_comb begin
        dout = '0;
        case (addr)
            CP0_SR:    dout = sr_word;
            CP0_CAUSE: dout = cause_word;
            CP0_EPC:   dout = epc;
            CP0_PRID:  dout = PRID_VAL;
            default:   dout = '0;
        endcase
    end

    assign handler_pc = HANDLER_ADDR;
    assign epc_out    = epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with a queue scoreboard of expected values.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID = 32'hCAFE_0001;
    localparam logic [31:0] HND  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] victim_pc;
    logic        victim_bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        INT_REQ;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passes = 0;

    always #10 clk = ~clk;

    cp0_exc_ctrl #(
        .WIDTH        (32),
        .HANDLER_ADDR (HND),
        .PRID_VAL     (PRID)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .victim_pc  (victim_pc),
        .victim_bd  (victim_bd),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .eret       (eret),
        .INT_REQ    (INT_REQ),
        .handler_pc (handler_pc),
        .epc_out    (epc_out)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: got %h required an expected entry", obs);
            return;
        end
        e = exp_q.pop_front();
        total++;
        assert (obs === e.val) passes++;
        else $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] v, input string tag);
        expect_val(tag, v);
        addr = a;
        #1;
        compare(dout);
    endtask

    task automatic ck_req(input logic v, input string tag);
        expect_val(tag, {31'd0, v});
        #1;
        compare({31'd0, INT_REQ});
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = 5'd0; din = '0;
        victim_pc = '0; victim_bd = 1'b0; exc_valid = 1'b0;
        exc_code = 5'd0; hw_int = 6'd0; eret = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd15, PRID, "rst_prid");
        rd(5'd3,  32'h0, "unmapped");
        ck_req(1'b0, "rst_int_req");
        expect_val("handler_pc", HND);
        compare(handler_pc);

        // enable IM[10] and IE
        @(negedge clk);
        we = 1'b1; addr = 5'd12; din = 32'h0000_0401;
        @(negedge clk);
        we = 1'b0;
        rd(5'd12, 32'h0000_0401, "sr_write");
        hw_int = 6'b000001; victim_pc = 32'h0000_3010; victim_bd = 1'b0;
        ck_req(1'b0, "irq_not_yet");
        @(negedge clk);
        ck_req(1'b1, "irq_raised");
        @(negedge clk);
        ck_req(1'b0, "irq_exl_drop");
        rd(5'd12, 32'h0000_0403, "irq_sr_exl");
        rd(5'd13, 32'h0000_0400, "irq_cause");
        rd(5'd14, 32'h0000_3010, "irq_epc");

        // leave handler with lines quiet
        hw_int = 6'd0; eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        ck_req(1'b0, "eret_quiet");
        exc_valid = 1'b1; exc_code = 5'd4;
        victim_pc = 32'h0000_2ffc; victim_bd = 1'b1;
        ck_req(1'b1, "adel_req");
        @(negedge clk);
        exc_valid = 1'b0;
        rd(5'd14, 32'h0000_2ff8, "bd_epc");
        rd(5'd13, 32'h8000_0010, "bd_cause");

        // interrupt and exception together
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0; victim_bd = 1'b0;
        hw_int = 6'b000001;
        @(negedge clk);
        exc_valid = 1'b1; exc_code = 5'd12; victim_pc = 32'h0000_5000;
        ck_req(1'b1, "both_req");
        @(negedge clk);
        exc_code = 5'd10; victim_pc = 32'h0000_6000;
        rd(5'd13, 32'h0000_0400, "prio_cause");
        rd(5'd14, 32'h0000_5000, "prio_epc");
        ck_req(1'b0, "exl_blocks_exc");
        @(negedge clk);
        exc_valid = 1'b0;
        rd(5'd14, 32'h0000_5000, "exl_epc_hold");

        // EPC write truncation, then eret with pending irq
        we = 1'b1; addr = 5'd14; din = 32'h0000_3007;
        @(negedge clk);
        we = 1'b0;
        rd(5'd14, 32'h0000_3004, "epc_write");
        expect_val("epc_out", 32'h0000_3004);
        compare(epc_out);
        eret = 1'b1;
        ck_req(1'b0, "eret_cycle");
        @(negedge clk);
        eret = 1'b0;
        rd(5'd12, 32'h0000_0401, "eret_exl_clr");
        victim_pc = 32'h0000_7000;
        ck_req(1'b1, "irq_reraise");

        // SR write coincident with INT_REQ is dropped
        we = 1'b1; addr = 5'd12; din = 32'h0;
        @(negedge clk);
        we = 1'b0;
        rd(5'd12, 32'h0000_0403, "sr_write_dropped");
        rd(5'd14, 32'h0000_7000, "reraise_epc");
        we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
        @(negedge clk);
        addr = 5'd15; din = 32'h1111_1111;
        @(negedge clk);
        we = 1'b0;
        rd(5'd13, 32'h0000_0400, "cause_ro");
        rd(5'd15, PRID, "prid_ro");

        // reset while EXL=1
        hw_int = 6'd0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(5'd12, 32'h0, "mid_rst_sr");
        rd(5'd13, 32'h0, "mid_rst_cause");
        rd(5'd14, 32'h0, "mid_rst_epc");
        ck_req(1'b0, "mid_rst_req");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
